// File: rtl/fabric_baud_ctrl_if.sv
// Handshake and status bundle between the fabric UART datapath and its baud-rate scheduler.
interface fabric_baud_ctrl_if #(
   parameter int unsigned DIV_W  = 16,
   parameter int unsigned FRAC_W = 4
);
   logic              ENABLE;
   logic              CFG_REQ;
   logic [DIV_W-1:0]  CFG_DIV;
   logic [FRAC_W-1:0] CFG_FRAC;
   logic              CFG_ACK;
   logic              READY;
   logic              TICK_X16;
   logic              TICK_TX;
   logic [DIV_W-1:0]  CUR_DIV;
   logic [FRAC_W-1:0] CUR_FRAC;

   modport master (
      output ENABLE, CFG_REQ, CFG_DIV, CFG_FRAC,
      input  CFG_ACK, READY, TICK_X16, TICK_TX, CUR_DIV, CUR_FRAC
   );

   modport slave (
      input  ENABLE, CFG_REQ, CFG_DIV, CFG_FRAC,
      output CFG_ACK, READY, TICK_X16, TICK_TX, CUR_DIV, CUR_FRAC
   );
endinterface

// File: rtl/fabric_baud_ctrl.sv
// Baud-rate scheduler: oscillator settle window, then x16 and bit ticks from a fractional divider.
// Divisor updates are handshaked and only take effect on a bit boundary or when the UART is idled.
module fabric_baud_ctrl #(
   parameter int unsigned STARTUP_CYCLES = 1024,
   parameter int unsigned DIV_W          = 16,
   parameter int unsigned FRAC_W         = 4,
   parameter int unsigned DEFAULT_DIV    = 27,
   parameter int unsigned DEFAULT_FRAC   = 2
) (
   input logic               CLK,
   input logic               RESET,
   fabric_baud_ctrl_if.slave bus
);

   localparam int unsigned      ST_W      = $clog2(STARTUP_CYCLES + 1);
   localparam logic [ST_W-1:0]  ST_LAST   = ST_W'(STARTUP_CYCLES - 1);
   localparam logic [DIV_W-1:0] DEF_DIV   = (DEFAULT_DIV < 2) ? DIV_W'(2) : DIV_W'(DEFAULT_DIV);
   localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEFAULT_FRAC);

   typedef enum logic [1:0] {ST_STARTUP, ST_IDLE, ST_RUN} state_e;

   state_e            state_q, state_d;
   logic [ST_W-1:0]   stcnt_q, stcnt_d;
   logic [DIV_W-1:0]  pcnt_q, pcnt_d;
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic [3:0]        scnt_q, scnt_d;
   logic              pend_q, pend_d;
   logic [DIV_W-1:0]  sh_div_q, sh_div_d;
   logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
   logic [DIV_W-1:0]  cur_div_q, cur_div_d;
   logic [FRAC_W-1:0] cur_frac_q, cur_frac_d;
   logic              ready_q, ready_d;
   logic              ack_q, ack_d;
   logic              tick_x16_q, tick_x16_d;
   logic              tick_tx_q, tick_tx_d;

   logic [FRAC_W:0]   cur_sum, nxt_sum;
   logic [DIV_W-1:0]  cur_last, nxt_last;
   logic              accept, apply_pend;

   function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
      return (d < DIV_W'(2)) ? DIV_W'(2) : d;
   endfunction

   // Terminal count of the current period: CUR_DIV-1, or CUR_DIV when the accumulator carries.
   assign cur_sum  = {1'b0, acc_q} + {1'b0, cur_frac_q};
   assign cur_last = cur_sum[FRAC_W] ? cur_div_q : cur_div_q - DIV_W'(1);

   always_comb begin
      state_d    = state_q;
      stcnt_d    = stcnt_q;
      pcnt_d     = pcnt_q;
      acc_d      = acc_q;
      scnt_d     = scnt_q;
      pend_d     = pend_q;
      sh_div_d   = sh_div_q;
      sh_frac_d  = sh_frac_q;
      cur_div_d  = cur_div_q;
      cur_frac_d = cur_frac_q;
      ready_d    = ready_q;
      ack_d      = 1'b0;
      apply_pend = 1'b0;
      accept     = bus.CFG_REQ && !pend_q && !ack_q;

      unique case (state_q)
         ST_STARTUP: begin
            stcnt_d    = stcnt_q + ST_W'(1);
            apply_pend = pend_q;
            if (stcnt_q == ST_LAST) begin
               state_d = bus.ENABLE ? ST_RUN : ST_IDLE;
               ready_d = 1'b1;
            end
         end
         ST_IDLE: begin
            apply_pend = pend_q;
            if (bus.ENABLE) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!bus.ENABLE) begin
               state_d    = ST_IDLE;
               pcnt_d     = '0;
               acc_d      = '0;
               scnt_d     = '0;
               apply_pend = pend_q;
            end else if (pcnt_q == cur_last) begin
               pcnt_d     = '0;
               acc_d      = cur_sum[FRAC_W-1:0];
               scnt_d     = scnt_q + 4'd1;
               apply_pend = pend_q && tick_tx_q;
            end else begin
               pcnt_d = pcnt_q + DIV_W'(1);
            end
         end
         default: state_d = ST_STARTUP;
      endcase

      // Outside RUN there is no character in flight, so a request is applied as soon as it is seen.
      if (apply_pend) begin
         cur_div_d  = sh_div_q;
         cur_frac_d = sh_frac_q;
         pend_d     = 1'b0;
         pcnt_d     = '0;
         acc_d      = '0;
         scnt_d     = '0;
         ack_d      = 1'b1;
      end else if (accept) begin
         if (state_q == ST_RUN) begin
            sh_div_d  = clamp_div(bus.CFG_DIV);
            sh_frac_d = bus.CFG_FRAC;
            pend_d    = 1'b1;
         end else begin
            cur_div_d  = clamp_div(bus.CFG_DIV);
            cur_frac_d = bus.CFG_FRAC;
            pcnt_d     = '0;
            acc_d      = '0;
            scnt_d     = '0;
            ack_d      = 1'b1;
         end
      end

      // Ticks are registered, so the terminal count is predicted from the next-cycle state.
      nxt_sum    = {1'b0, acc_d} + {1'b0, cur_frac_d};
      nxt_last   = nxt_sum[FRAC_W] ? cur_div_d : cur_div_d - DIV_W'(1);
      tick_x16_d = (state_d == ST_RUN) && (pcnt_d == nxt_last);
      tick_tx_d  = tick_x16_d && (scnt_d == 4'hF);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_STARTUP;
         stcnt_q    <= '0;
         pcnt_q     <= '0;
         acc_q      <= '0;
         scnt_q     <= '0;
         pend_q     <= 1'b0;
         sh_div_q   <= DEF_DIV;
         sh_frac_q  <= DEF_FRAC;
         cur_div_q  <= DEF_DIV;
         cur_frac_q <= DEF_FRAC;
         ready_q    <= 1'b0;
         ack_q      <= 1'b0;
         tick_x16_q <= 1'b0;
         tick_tx_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         stcnt_q    <= stcnt_d;
         pcnt_q     <= pcnt_d;
         acc_q      <= acc_d;
         scnt_q     <= scnt_d;
         pend_q     <= pend_d;
         sh_div_q   <= sh_div_d;
         sh_frac_q  <= sh_frac_d;
         cur_div_q  <= cur_div_d;
         cur_frac_q <= cur_frac_d;
         ready_q    <= ready_d;
         ack_q      <= ack_d;
         tick_x16_q <= tick_x16_d;
         tick_tx_q  <= tick_tx_d;
      end
   end

   assign bus.READY    = ready_q;
   assign bus.CFG_ACK  = ack_q;
   assign bus.TICK_X16 = tick_x16_q;
   assign bus.TICK_TX  = tick_tx_q;
   assign bus.CUR_DIV  = cur_div_q;
   assign bus.CUR_FRAC = cur_frac_q;

endmodule

// File: tb/tb_fabric_baud_ctrl.sv
// Self-checking bench for fabric_baud_ctrl; tick times are predicted from divisor arithmetic.
module tb_fabric_baud_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   x16_q[$];
   int   tx_q[$];
   int   ack_q[$];
   int   consec = 0;
   logic prev_x16 = 1'b0, prev_tx = 1'b0, prev_ack = 1'b0;
   int   m_div = 27, m_frac = 2;

   fabric_baud_ctrl_if #(.DIV_W(16), .FRAC_W(4)) bus ();

   fabric_baud_ctrl #(
      .STARTUP_CYCLES(8),
      .DIV_W(16),
      .FRAC_W(4),
      .DEFAULT_DIV(27),
      .DEFAULT_FRAC(2)
   ) dut (
      .CLK(clk),
      .RESET(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.TICK_X16) x16_q.push_back(cyc);
      if (bus.TICK_TX) tx_q.push_back(cyc);
      if (bus.CFG_ACK) ack_q.push_back(cyc);
      if ((bus.TICK_X16 && prev_x16) || (bus.TICK_TX && prev_tx) || (bus.CFG_ACK && prev_ack))
         consec <= consec + 1;
      prev_x16 <= bus.TICK_X16;
      prev_tx  <= bus.TICK_TX;
      prev_ack <= bus.CFG_ACK;
   end

   // Period k after a restart: the accumulator holds k*frac mod 16, so it carries when floor() steps.
   function automatic int period_len(input int div, input int frac, input int k);
      return div + ((k + 1) * frac) / 16 - (k * frac) / 16;
   endfunction

   // Cycle of tick k when the first RUN cycle (pcnt = 0) is cycle base.
   function automatic int exp_tick(input int base, input int div, input int frac, input int k);
      int t = base - 1;
      for (int j = 0; j <= k; j++) t += period_len(div, frac, j);
      return t;
   endfunction

   function automatic int clampd(input int d);
      return (d < 2) ? 2 : d;
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic stepn(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_x16(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && x16_q.size() < n; i++) step();
      if (x16_q.size() >= n) ok = 1'b1;
   endtask

   task automatic test_reset(output int run_base);
      int c;
      rst = 1'b1;
      bus.ENABLE = 1'b1;
      bus.CFG_REQ = 1'b0;
      bus.CFG_DIV = '0;
      bus.CFG_FRAC = '0;
      stepn(3);
      checks++;
      if ({bus.READY, bus.TICK_X16, bus.TICK_TX, bus.CFG_ACK} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=0000", {bus.READY, bus.TICK_X16, bus.TICK_TX, bus.CFG_ACK});
      end
      checks++;
      if (bus.CUR_DIV !== 16'd27 || bus.CUR_FRAC !== 4'd2) begin
         failures++;
         $display("FAIL reset_div got=%0d/%0d exp=27/2", bus.CUR_DIV, bus.CUR_FRAC);
      end
      rst = 1'b0;
      c = cyc;
      for (int i = 0; i < 40 && !bus.READY; i++) step();
      run_base = cyc;
      checks++;
      if (cyc - c !== 8 || bus.READY !== 1'b1) begin
         failures++;
         $display("FAIL ready_delay got=%0d exp=8", cyc - c);
      end
   endtask

   task automatic test_default_rate(input int base);
      bit ok;
      int prev, longs;
      x16_q.delete();
      tx_q.delete();
      wait_x16(64, 2000, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL default_timeout got=%0d exp=64", x16_q.size()); end
      for (int k = 0; k < 64 && k < x16_q.size(); k++) begin
         checks++;
         if (x16_q[k] !== exp_tick(base, 27, 2, k)) begin
            failures++;
            $display("FAIL default_tick%0d got=%0d exp=%0d", k, x16_q[k], exp_tick(base, 27, 2, k));
         end
      end
      prev = base - 1;
      longs = 0;
      for (int k = 0; k < 16 && k < x16_q.size(); k++) begin
         if (x16_q[k] - prev == 28) longs++;
         prev = x16_q[k];
      end
      checks++;
      if (longs !== 2) begin failures++; $display("FAIL default_long_periods got=%0d exp=2", longs); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (tx_q.size() < i + 2) begin
            failures++;
            $display("FAIL default_tx_count got=%0d exp=%0d", tx_q.size(), i + 2);
         end else if (tx_q[i + 1] - tx_q[i] !== 434) begin
            failures++;
            $display("FAIL default_tx_interval got=%0d exp=434", tx_q[i + 1] - tx_q[i]);
         end
      end
   endtask

   task automatic test_cfg_run(input int nd, input int nf);
      int t, a;
      bit early, ok;
      int ed;
      ed = clampd(nd);
      tx_q.delete();
      for (int i = 0; i < 2000 && tx_q.size() == 0; i++) step();
      t = (tx_q.size() > 0) ? tx_q[0] : -1;
      stepn(5);
      bus.CFG_REQ = 1'b1;
      bus.CFG_DIV = 16'(nd);
      bus.CFG_FRAC = 4'(nf);
      early = 1'b0;
      a = -1;
      for (int i = 0; i < 2000; i++) begin
         step();
         if (bus.CFG_ACK) begin a = cyc; break; end
         if (bus.CUR_DIV !== 16'(m_div) || bus.CUR_FRAC !== 4'(m_frac)) early = 1'b1;
      end
      bus.CFG_REQ = 1'b0;
      checks++;
      if (early) begin failures++; $display("FAIL run_cfg_early got=1 exp=0"); end
      checks++;
      if (a !== t + 16 * m_div + m_frac + 1) begin
         failures++;
         $display("FAIL run_cfg_ack_cycle got=%0d exp=%0d", a, t + 16 * m_div + m_frac + 1);
      end
      checks++;
      if (bus.CUR_DIV !== 16'(ed) || bus.CUR_FRAC !== 4'(nf)) begin
         failures++;
         $display("FAIL run_cfg_cur got=%0d/%0d exp=%0d/%0d", bus.CUR_DIV, bus.CUR_FRAC, ed, nf);
      end
      m_div = ed;
      m_frac = nf;
      x16_q.delete();
      tx_q.delete();
      wait_x16(32, 32 * (ed + 1) + 50, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL run_cfg_timeout got=%0d exp=32", x16_q.size()); end
      for (int k = 0; k < 32 && k < x16_q.size(); k++) begin
         checks++;
         if (x16_q[k] !== exp_tick(a, ed, nf, k)) begin
            failures++;
            $display("FAIL run_cfg_tick%0d got=%0d exp=%0d", k, x16_q[k], exp_tick(a, ed, nf, k));
         end
      end
      checks++;
      if (tx_q.size() < 2) begin
         failures++;
         $display("FAIL run_cfg_tx_count got=%0d exp=2", tx_q.size());
      end else if (tx_q[1] - tx_q[0] !== 16 * ed + nf) begin
         failures++;
         $display("FAIL run_cfg_tx_interval got=%0d exp=%0d", tx_q[1] - tx_q[0], 16 * ed + nf);
      end
   endtask

   task automatic test_cfg_idle_min();
      int e;
      bit ok;
      bus.ENABLE = 1'b0;
      step();
      x16_q.delete();
      stepn(5);
      checks++;
      if (x16_q.size() !== 0) begin failures++; $display("FAIL idle_no_ticks got=%0d exp=0", x16_q.size()); end
      bus.CFG_REQ = 1'b1;
      bus.CFG_DIV = 16'($urandom_range(0, 1));
      bus.CFG_FRAC = 4'd0;
      step();
      checks++;
      if (bus.CFG_ACK !== 1'b1 || bus.CUR_DIV !== 16'd2 || bus.CUR_FRAC !== 4'd0) begin
         failures++;
         $display("FAIL idle_clamp got=ack%0d/%0d/%0d exp=ack1/2/0", bus.CFG_ACK, bus.CUR_DIV, bus.CUR_FRAC);
      end
      bus.CFG_REQ = 1'b0;
      m_div = 2;
      m_frac = 0;
      stepn(2);
      x16_q.delete();
      tx_q.delete();
      bus.ENABLE = 1'b1;
      e = cyc;
      wait_x16(32, 200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL min_div_timeout got=%0d exp=32", x16_q.size()); end
      for (int k = 0; k < 32 && k < x16_q.size(); k++) begin
         checks++;
         if (x16_q[k] !== exp_tick(e + 1, 2, 0, k)) begin
            failures++;
            $display("FAIL min_div_tick%0d got=%0d exp=%0d", k, x16_q[k], exp_tick(e + 1, 2, 0, k));
         end
      end
      checks++;
      if (tx_q.size() < 2) begin
         failures++;
         $display("FAIL min_div_tx_count got=%0d exp=2", tx_q.size());
      end else if (tx_q[1] - tx_q[0] !== 32) begin
         failures++;
         $display("FAIL min_div_tx_interval got=%0d exp=32", tx_q[1] - tx_q[0]);
      end
   endtask

   task automatic test_enable_drop_pending();
      int d1, f1, d2, f2, e;
      bit ok;
      d1 = $urandom_range(6, 20);
      f1 = $urandom_range(0, 15);
      d2 = $urandom_range(0, 40);
      f2 = $urandom_range(0, 15);
      bus.ENABLE = 1'b0;
      stepn(2);
      bus.CFG_REQ = 1'b1;
      bus.CFG_DIV = 16'(d1);
      bus.CFG_FRAC = 4'(f1);
      step();
      checks++;
      if (bus.CFG_ACK !== 1'b1 || bus.CUR_DIV !== 16'(d1)) begin
         failures++;
         $display("FAIL idle_cfg got=ack%0d/%0d exp=ack1/%0d", bus.CFG_ACK, bus.CUR_DIV, d1);
      end
      bus.CFG_REQ = 1'b0;
      bus.ENABLE = 1'b1;
      stepn($urandom_range(3, 20));
      bus.CFG_REQ = 1'b1;
      bus.CFG_DIV = 16'(d2);
      bus.CFG_FRAC = 4'(f2);
      ack_q.delete();
      stepn($urandom_range(2, 20));
      checks++;
      if (ack_q.size() !== 0 || bus.CUR_DIV !== 16'(d1) || bus.CUR_FRAC !== 4'(f1)) begin
         failures++;
         $display("FAIL drop_pending_early got=%0d/%0d exp=%0d/%0d", bus.CUR_DIV, bus.CUR_FRAC, d1, f1);
      end
      bus.ENABLE = 1'b0;
      step();
      checks++;
      if (bus.CFG_ACK !== 1'b1 || bus.CUR_DIV !== 16'(clampd(d2)) || bus.CUR_FRAC !== 4'(f2)) begin
         failures++;
         $display("FAIL drop_apply got=ack%0d/%0d/%0d exp=ack1/%0d/%0d",
                  bus.CFG_ACK, bus.CUR_DIV, bus.CUR_FRAC, clampd(d2), f2);
      end
      bus.CFG_REQ = 1'b0;
      m_div = clampd(d2);
      m_frac = f2;
      x16_q.delete();
      tx_q.delete();
      stepn(5);
      checks++;
      if (x16_q.size() !== 0) begin failures++; $display("FAIL drop_idle_ticks got=%0d exp=0", x16_q.size()); end
      bus.ENABLE = 1'b1;
      e = cyc;
      wait_x16(16, 16 * (m_div + 1) + 50, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL reenable_timeout got=%0d exp=16", x16_q.size()); end
      for (int k = 0; k < 16 && k < x16_q.size(); k++) begin
         checks++;
         if (x16_q[k] !== exp_tick(e + 1, m_div, m_frac, k)) begin
            failures++;
            $display("FAIL reenable_tick%0d got=%0d exp=%0d", k, x16_q[k], exp_tick(e + 1, m_div, m_frac, k));
         end
      end
      checks++;
      if (tx_q.size() !== 1 || x16_q.size() < 16 || tx_q[0] !== x16_q[15]) begin
         failures++;
         $display("FAIL reenable_tx got=%0d exp=1 aligned with tick 15", tx_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int c;
      bus.CFG_REQ = 1'b1;
      bus.CFG_DIV = 16'($urandom_range(3, 40));
      bus.CFG_FRAC = 4'($urandom_range(0, 15));
      stepn(3);
      rst = 1'b1;
      step();
      checks++;
      if ({bus.READY, bus.TICK_X16, bus.TICK_TX, bus.CFG_ACK} !== 4'b0000 ||
          bus.CUR_DIV !== 16'd27 || bus.CUR_FRAC !== 4'd2) begin
         failures++;
         $display("FAIL midreset_state got=%b/%0d/%0d exp=0000/27/2",
                  {bus.READY, bus.TICK_X16, bus.TICK_TX, bus.CFG_ACK}, bus.CUR_DIV, bus.CUR_FRAC);
      end
      rst = 1'b0;
      bus.CFG_REQ = 1'b0;
      ack_q.delete();
      c = cyc;
      for (int i = 0; i < 40 && !bus.READY; i++) step();
      checks++;
      if (cyc - c !== 8) begin failures++; $display("FAIL midreset_ready got=%0d exp=8", cyc - c); end
      checks++;
      if (ack_q.size() !== 0 || bus.CUR_DIV !== 16'd27) begin
         failures++;
         $display("FAIL midreset_discard got=acks%0d/%0d exp=acks0/27", ack_q.size(), bus.CUR_DIV);
      end
   endtask

   task automatic test_no_consecutive();
      checks++;
      if (consec !== 0) begin failures++; $display("FAIL consecutive_pulses got=%0d exp=0", consec); end
   endtask

   initial begin
      int base;
      test_reset(base);
      test_default_rate(base);
      test_cfg_run(10, 0);
      for (int i = 0; i < 2; i++) test_cfg_run($urandom_range(2, 40), $urandom_range(0, 15));
      test_cfg_idle_min();
      test_enable_drop_pending();
      test_reset_mid();
      test_no_consecutive();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
